// File: rtl/bullet_launcher_if.sv
// Bundle of the bullet launcher's control inputs and bullet/status outputs.
// master drives the player/frame side, slave is the launcher itself.
interface bullet_launcher_if;
   logic        startOfFrame;
   logic        fireKey;
   logic        pause;
   logic        restart_loc;
   logic [10:0] playerX;
   logic [10:0] playerY;
   logic [10:0] enemyTopY;
   logic [2:0]  enemyHit;
   logic [10:0] bulletX;
   logic [10:0] bulletY;
   logic        bulletActive;
   logic [2:0]  shotCollision;
   logic        dodgeBullet;
   logic [1:0]  dbg_state;   // launcher FSM state: 0 READY, 1 FLYING, 2 COOLDOWN

   modport master (
      output startOfFrame, fireKey, pause, restart_loc,
      output playerX, playerY, enemyTopY, enemyHit,
      input  bulletX, bulletY, bulletActive, shotCollision, dodgeBullet, dbg_state
   );

   modport slave (
      input  startOfFrame, fireKey, pause, restart_loc,
      input  playerX, playerY, enemyTopY, enemyHit,
      output bulletX, bulletY, bulletActive, shotCollision, dodgeBullet, dbg_state
   );
endinterface

// File: rtl/bullet_launcher.sv
// Single-bullet launcher: spawns a bullet above the player on a fire edge,
// moves it up once per frame, reports the first enemy it hits, raises a dodge
// warning near the enemy row and enforces a frame-counted cooldown.
// Inputs are levels sampled every clock; there is no valid/ready handshake:
// fire is the rising edge of fireKey, shotCollision is a one-cycle pulse.
module bullet_launcher #(
   parameter int X_OFFSET        = 14,
   parameter int Y_OFFSET        = 8,
   parameter int BULLET_SPEED    = 4,
   parameter int DODGE_WINDOW    = 40,
   parameter int COOLDOWN_FRAMES = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   bullet_launcher_if.slave         bus
);

   typedef enum logic [1:0] {
      READY    = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   localparam logic [10:0] X_OFF   = 11'(X_OFFSET);
   localparam logic [10:0] Y_OFF   = 11'(Y_OFFSET);
   localparam logic [10:0] SPEED   = 11'(BULLET_SPEED);
   localparam logic [10:0] DODGE_W = 11'(DODGE_WINDOW);
   localparam logic [3:0]  CNT_END = 4'(COOLDOWN_FRAMES - 1);

   state_t      state_q, state_d;
   logic [10:0] bullet_x_q, bullet_x_d;
   logic [10:0] bullet_y_q, bullet_y_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  shot_q, shot_d;
   logic        dodge_q, dodge_d;
   logic        fire_key_q;

   logic        fire;
   logic        tick;
   logic [2:0]  hit_first;
   logic [10:0] dodge_diff;

   // Rising edge of the fire key; edges seen while paused are dropped.
   assign fire = bus.fireKey & ~fire_key_q & ~bus.pause;
   assign tick = bus.startOfFrame & ~bus.pause;

   // Only the lowest-index enemy is reported when several overlap the bullet.
   assign hit_first = bus.enemyHit[0] ? 3'b001 :
                      bus.enemyHit[1] ? 3'b010 :
                      bus.enemyHit[2] ? 3'b100 : 3'b000;

   assign dodge_diff = bullet_y_q - bus.enemyTopY;

   // Next-state, bullet motion, hit report and cooldown counting.
   always_comb begin
      state_d    = state_q;
      bullet_x_d = bullet_x_q;
      bullet_y_d = bullet_y_q;
      cnt_d      = cnt_q;
      shot_d     = 3'b000;
      dodge_d    = 1'b0;
      unique case (state_q)
         READY: begin
            if (fire) begin
               state_d    = FLYING;
               bullet_x_d = bus.playerX + X_OFF;
               bullet_y_d = (bus.playerY < Y_OFF) ? 11'd0 : bus.playerY - Y_OFF;
            end
         end
         FLYING: begin
            if (!bus.pause && hit_first != 3'b000) begin
               // A hit wins over a simultaneous top exit.
               state_d    = COOLDOWN;
               shot_d     = hit_first;
               bullet_x_d = 11'd0;
               bullet_y_d = 11'd0;
               cnt_d      = 4'd0;
            end else if (tick) begin
               if (bullet_y_q < SPEED) begin
                  // Leaving the top of the screen; never let Y wrap.
                  state_d    = COOLDOWN;
                  bullet_x_d = 11'd0;
                  bullet_y_d = 11'd0;
                  cnt_d      = 4'd0;
               end else begin
                  bullet_y_d = bullet_y_q - SPEED;
               end
            end
            // Warning is judged on the current position; dropped if the
            // bullet is leaving flight this cycle so it is never seen outside FLYING.
            dodge_d = !bus.pause && (state_d == FLYING) &&
                      (bullet_y_q >= bus.enemyTopY) && (dodge_diff <= DODGE_W);
         end
         COOLDOWN: begin
            if (tick) begin
               if (cnt_q == CNT_END) begin
                  state_d = READY;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   // State and output registers; reset and level restart behave identically.
   always_ff @(posedge clk) begin
      if (reset || bus.restart_loc) begin
         state_q    <= READY;
         bullet_x_q <= 11'd0;
         bullet_y_q <= 11'd0;
         cnt_q      <= 4'd0;
         shot_q     <= 3'b000;
         dodge_q    <= 1'b0;
         fire_key_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         bullet_x_q <= bullet_x_d;
         bullet_y_q <= bullet_y_d;
         cnt_q      <= cnt_d;
         shot_q     <= shot_d;
         dodge_q    <= dodge_d;
         fire_key_q <= bus.fireKey;
      end
   end

   assign bus.bulletX       = bullet_x_q;
   assign bus.bulletY       = bullet_y_q;
   assign bus.bulletActive  = (state_q == FLYING);
   assign bus.shotCollision = shot_q;
   assign bus.dodgeBullet   = dodge_q;
   assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_bullet_launcher.sv
// Directed bench for bullet_launcher: spawn, flight, pause, dodge window,
// hit priority, top exit, cooldown length, restart and reset.
module tb_bullet_launcher;

   localparam int S_READY    = 0;
   localparam int S_FLYING   = 1;
   localparam int S_COOLDOWN = 2;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   bullet_launcher_if bus ();

   bullet_launcher dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One frame tick lasting a single cycle.
   task automatic tick();
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
   endtask

   // Produce a fireKey rising edge; the edge is seen at the second clock.
   task automatic fire_edge();
      bus.fireKey = 1'b0;
      step();
      bus.fireKey = 1'b1;
      step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, 32'(bus.dbg_state), S_READY);
      chk({tag, "_bx"},    32'(bus.bulletX), 0);
      chk({tag, "_by"},    32'(bus.bulletY), 0);
      chk({tag, "_act"},   32'(bus.bulletActive), 0);
      chk({tag, "_shot"},  32'(bus.shotCollision), 0);
      chk({tag, "_dodge"}, 32'(bus.dodgeBullet), 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.fireKey      = 1'b1;   // held through reset
      bus.pause        = 1'b0;
      bus.restart_loc  = 1'b0;
      bus.playerX      = 11'd300;
      bus.playerY      = 11'd400;
      bus.enemyTopY    = 11'd1000;
      bus.enemyHit     = 3'b000;
      step();
      step();
      reset = 1'b0;
      step();
      chk_idle("reset");
      step();
      chk("held_key_no_fire", 32'(bus.dbg_state), S_READY);

      // Spawn at player offset, then three frames of upward motion.
      fire_edge();
      chk("spawn_state", 32'(bus.dbg_state), S_FLYING);
      chk("spawn_act",   32'(bus.bulletActive), 1);
      chk("spawn_bx",    32'(bus.bulletX), 314);
      chk("spawn_by",    32'(bus.bulletY), 392);
      tick();
      tick();
      tick();
      chk("move3_by", 32'(bus.bulletY), 380);
      chk("move3_bx", 32'(bus.bulletX), 314);
      step();
      chk("held_no_refire_by", 32'(bus.bulletY), 380);
      fire_edge();
      chk("fire_in_flight_ignored", 32'(bus.bulletY), 380);

      // Pause freezes motion and masks hits.
      bus.pause    = 1'b1;
      bus.enemyHit = 3'b001;
      for (int i = 0; i < 5; i++) tick();
      chk("pause_by",    32'(bus.bulletY), 380);
      chk("pause_shot",  32'(bus.shotCollision), 0);
      chk("pause_state", 32'(bus.dbg_state), S_FLYING);
      bus.pause    = 1'b0;
      bus.enemyHit = 3'b000;

      // Level restart mid-flight.
      bus.restart_loc = 1'b1;
      step();
      bus.restart_loc = 1'b0;
      chk_idle("restart");

      // Dodge window: enemy row at 210, bullet passes 254, 250, 246.
      bus.enemyTopY = 11'd210;
      bus.playerY   = 11'd262;
      fire_edge();
      chk("dodge_spawn_by", 32'(bus.bulletY), 254);
      step();
      chk("dodge_at254", 32'(bus.dodgeBullet), 0);
      tick();
      chk("dodge_by250",  32'(bus.bulletY), 250);
      chk("dodge_lat",    32'(bus.dodgeBullet), 0);
      step();
      chk("dodge_at250", 32'(bus.dodgeBullet), 1);
      tick();
      chk("dodge_by246", 32'(bus.bulletY), 246);
      chk("dodge_at246", 32'(bus.dodgeBullet), 1);

      // Two overlapping enemies held for two cycles: single lowest-index pulse.
      bus.enemyHit = 3'b110;
      step();
      chk("hit_shot",  32'(bus.shotCollision), 3'b010);
      chk("hit_state", 32'(bus.dbg_state), S_COOLDOWN);
      chk("hit_act",   32'(bus.bulletActive), 0);
      chk("hit_dodge", 32'(bus.dodgeBullet), 0);
      chk("hit_by",    32'(bus.bulletY), 0);
      step();
      chk("hit_pulse_end", 32'(bus.shotCollision), 0);
      bus.enemyHit = 3'b000;

      // Cooldown lasts exactly ten frames; fire at frame 9 is dropped.
      for (int i = 0; i < 9; i++) tick();
      chk("cool9_state", 32'(bus.dbg_state), S_COOLDOWN);
      fire_edge();
      chk("cool9_fire_ignored", 32'(bus.dbg_state), S_COOLDOWN);
      tick();
      chk("cool10_state", 32'(bus.dbg_state), S_READY);
      fire_edge();
      chk("rearm_fire", 32'(bus.dbg_state), S_FLYING);

      // Top exit from bulletY=3 gives no collision report.
      bus.restart_loc = 1'b1;
      step();
      bus.restart_loc = 1'b0;
      bus.playerY = 11'd11;
      bus.playerX = 11'd100;
      fire_edge();
      chk("low_spawn_by", 32'(bus.bulletY), 3);
      chk("low_spawn_bx", 32'(bus.bulletX), 114);
      tick();
      chk("top_exit_state", 32'(bus.dbg_state), S_COOLDOWN);
      chk("top_exit_shot",  32'(bus.shotCollision), 0);
      chk("top_exit_by",    32'(bus.bulletY), 0);

      // Reset mid-cooldown, then spawn clamped at Y=0.
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_idle("reset_cool");
      bus.playerY = 11'd5;
      fire_edge();
      chk("clamp_state", 32'(bus.dbg_state), S_FLYING);
      chk("clamp_by",    32'(bus.bulletY), 0);

      // Hit and top exit in the same cycle resolve as a hit.
      bus.enemyHit     = 3'b100;
      bus.startOfFrame = 1'b1;
      step();
      bus.enemyHit     = 3'b000;
      bus.startOfFrame = 1'b0;
      chk("hit_vs_exit_shot",  32'(bus.shotCollision), 3'b100);
      chk("hit_vs_exit_state", 32'(bus.dbg_state), S_COOLDOWN);

      // Reset mid-flight outranks a simultaneous fire edge and hit.
      for (int i = 0; i < 10; i++) tick();
      chk("cool_done_state", 32'(bus.dbg_state), S_READY);
      bus.playerY   = 11'd230;
      bus.enemyTopY = 11'd200;
      fire_edge();
      step();
      chk("pre_reset_dodge", 32'(bus.dodgeBullet), 1);
      bus.fireKey  = 1'b0;
      step();
      reset        = 1'b1;
      bus.fireKey  = 1'b1;
      bus.enemyHit = 3'b001;
      step();
      reset        = 1'b0;
      bus.enemyHit = 3'b000;
      chk_idle("reset_flight");
      step();
      chk("post_reset_no_fire", 32'(bus.dbg_state), S_READY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
